// File: rtl/jh_interleave_fifo_ctrl_pkg.sv
// Shared types and helpers for the interleaved FIFO sequencer.
// Holds the FSM state type and the round-robin wrap increment.
package jh_interleave_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int unsigned bank_idx_next(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/jh_interleave_fifo_ctrl_if.sv
// Upstream/downstream valid-ready stream bundle for the sequencer.
// Ports: in_data/in_valid/in_ready, out_data/out_valid/out_ready.
interface jh_interleave_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/jh_interleave_fifo_ctrl_rr_ptr.sv
// Round-robin bank pointer: wraps N-1 -> 0 on adv.
// Ports: clk, rst (sync), clr (sync zero), adv (step), ptr (current bank).
module jh_rr_ptr
    import jh_interleave_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [PW-1:0] ptr
);
    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ptr <= '0;
        end else if (adv) begin
            r_ptr <= PW'(bank_idx_next(32'(r_ptr), N));
        end
    end

    assign ptr = r_ptr;
endmodule

// File: rtl/jh_interleave_fifo_ctrl.sv
// Sequencer spreading one stream round-robin over external bank FIFOs.
// Ports: clk, rst, stream bus s, clear, count, err, bank_* strobes/data.
module jh_interleave_fifo_ctrl
    import jh_interleave_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    jh_interleave_fifo_ctrl_if.slave        s,
    input  logic                            clear,
    output logic [$clog2(NUM_BANKS*BANK_DEPTH):0] count,
    output logic                            err,
    output logic [DATA_WIDTH-1:0]           bank_wr_data,
    output logic [NUM_BANKS-1:0]            bank_wr_valid,
    input  logic [NUM_BANKS-1:0]            bank_wr_ready,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rd_data,
    input  logic [NUM_BANKS-1:0]            bank_rd_valid,
    output logic [NUM_BANKS-1:0]            bank_rd_ready,
    output logic [NUM_BANKS-1:0]            bank_clear
);
    localparam int TOTAL = NUM_BANKS * BANK_DEPTH;
    localparam int CW    = $clog2(TOTAL) + 1;
    localparam int PW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    state_t               r_state;
    state_t               w_state_nx;
    logic [CW-1:0]        r_count;
    logic                 r_err;
    logic [PW-1:0]        w_wr_ptr;
    logic [PW-1:0]        w_rd_ptr;
    logic [NUM_BANKS-1:0] w_wr_sel;
    logic [NUM_BANKS-1:0] w_rd_sel;
    logic                 w_run;
    logic                 w_idle;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_zero;
    logic                 w_err_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            INIT:    w_state_nx = RUN;
            RUN:     w_state_nx = clear ? FLUSH : RUN;
            FLUSH:   w_state_nx = clear ? FLUSH : RUN;
            default: w_state_nx = INIT;
        endcase
    end

    // Reset is folded in so the bus is quiet while rst is held.
    assign w_idle  = rst || (r_state != RUN);
    assign w_run   = !w_idle;
    assign w_full  = (r_count == CW'(TOTAL));
    assign w_empty = (r_count == '0);

    assign w_wr_sel = NUM_BANKS'(1) << w_wr_ptr;
    assign w_rd_sel = NUM_BANKS'(1) << w_rd_ptr;

    // Ready/valid are built only from state, never from the peer's strobe.
    assign s.in_ready  = w_run && bank_wr_ready[w_wr_ptr]
                         && !w_full && !clear;
    assign s.out_valid = w_run && bank_rd_valid[w_rd_ptr]
                         && !w_empty && !clear;
    assign s.out_data  = bank_rd_data[w_rd_ptr*DATA_WIDTH +: DATA_WIDTH];

    assign w_in_fire  = s.in_valid && s.in_ready;
    assign w_out_fire = s.out_valid && s.out_ready;

    assign bank_wr_data  = s.in_data;
    assign bank_wr_valid = w_in_fire ? w_wr_sel : '0;
    assign bank_rd_ready = w_out_fire ? w_rd_sel : '0;
    assign bank_clear    = {NUM_BANKS{w_idle}};

    // Zeroing on the clear edge itself makes the flush visible one
    // cycle earlier; the banks are emptied while in FLUSH.
    assign w_zero = w_idle || clear;

    jh_rr_ptr #(.N(NUM_BANKS), .PW(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (w_zero),
        .adv (w_in_fire),
        .ptr (w_wr_ptr)
    );

    jh_rr_ptr #(.N(NUM_BANKS), .PW(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (w_zero),
        .adv (w_out_fire),
        .ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst || w_zero) begin
            r_count <= '0;
        end else if (w_in_fire && !w_out_fire) begin
            r_count <= r_count + 1'b1;
        end else if (w_out_fire && !w_in_fire) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Either the bank we expect data from is dry, or the round-robin
    // target is full while some other bank still has room.
    assign w_err_set = w_run && (
        (!w_empty && !bank_rd_valid[w_rd_ptr]) ||
        (s.in_valid && !w_full && !bank_wr_ready[w_wr_ptr]
         && |(bank_wr_ready & ~w_wr_sel)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign count = r_count;
    assign err   = r_err;
endmodule

// File: tb/tb_jh_interleave_fifo_ctrl.sv
// Bench for jh_interleave_fifo_ctrl with four behavioural bank FIFOs.
// Scoreboard queue fed on accepted input, drained on accepted output.
module tb_jh_interleave_fifo_ctrl;
    localparam int DW = 8;
    localparam int NB = 4;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [4:0]    count;
    logic          err;
    logic [DW-1:0] bank_wr_data;
    logic [NB-1:0] bank_wr_valid;
    logic [NB-1:0] bank_wr_ready;
    logic [NB*DW-1:0] bank_rd_data;
    logic [NB-1:0] bank_rd_valid;
    logic [NB-1:0] bank_rd_ready;
    logic [NB-1:0] bank_clear;

    jh_interleave_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus();

    jh_interleave_fifo_ctrl #(
        .DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_DEPTH(BD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s             (bus),
        .clear         (clear),
        .count         (count),
        .err           (err),
        .bank_wr_data  (bank_wr_data),
        .bank_wr_valid (bank_wr_valid),
        .bank_wr_ready (bank_wr_ready),
        .bank_rd_data  (bank_rd_data),
        .bank_rd_valid (bank_rd_valid),
        .bank_rd_ready (bank_rd_ready),
        .bank_clear    (bank_clear)
    );

    always #5 clk = ~clk;

    // Behavioural bank FIFOs (registered write, first-word visible).
    logic [DW-1:0] mem [NB][BD];
    logic [1:0]    wp  [NB];
    logic [1:0]    rp  [NB];
    logic [2:0]    cnt [NB];

    always_comb begin
        bank_wr_ready = '0;
        bank_rd_valid = '0;
        bank_rd_data  = '0;
        for (int k = 0; k < NB; k++) begin
            bank_wr_ready[k] = (cnt[k] < 3'd4);
            bank_rd_valid[k] = (cnt[k] != 3'd0);
            bank_rd_data[k*DW +: DW] = mem[k][rp[k]];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (bank_clear[k]) begin
                wp[k]  <= '0;
                rp[k]  <= '0;
                cnt[k] <= '0;
            end else begin
                if (bank_wr_valid[k] && cnt[k] < 3'd4) begin
                    mem[k][wp[k]] <= bank_wr_data;
                    wp[k] <= wp[k] + 2'd1;
                end
                if (bank_rd_ready[k] && cnt[k] != 3'd0)
                    rp[k] <= rp[k] + 2'd1;
                cnt[k] <= cnt[k]
                    + 3'(bank_wr_valid[k] && cnt[k] < 3'd4)
                    - 3'(bank_rd_ready[k] && cnt[k] != 3'd0);
            end
        end
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_push = 0;
    bit            chk_cnt = 1'b0;
    logic [DW-1:0] q [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sees the handshakes that will fire at the next edge.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (chk_cnt)
            check("count_track", 32'(count), 32'(q.size()));
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("pop_unexpected", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e));
            end
        end
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            q.push_back(bus.in_data);
            n_push++;
        end
    end

    initial begin
        int cyc;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // 1: reset and INIT
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("init_bank_clear", 32'(bank_clear), 32'hF);
        check("init_in_ready", 32'(bus.in_ready), 32'h0);
        check("init_out_valid", 32'(bus.out_valid), 32'h0);
        tick();
        @(negedge clk);
        check("run_in_ready", 32'(bus.in_ready), 32'h1);
        check("run_out_valid", 32'(bus.out_valid), 32'h0);
        check("run_count", 32'(count), 32'h0);
        check("run_err", 32'(err), 32'h0);
        check("run_bank_clear", 32'(bank_clear), 32'h0);
        tick();
        chk_cnt = 1'b1;

        // 2: fill 0x10..0x1F
        bus.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_data = 8'h10 + 8'(i);
            @(negedge clk);
            check("fill_wr_strobe", 32'(bank_wr_valid), 32'(1 << (i % 4)));
            tick();
        end
        bus.in_data = 8'hFF;
        @(negedge clk);
        check("full_count", 32'(count), 32'd16);
        check("full_in_ready", 32'(bus.in_ready), 32'h0);
        check("full_no_write", 32'(bank_wr_valid), 32'h0);
        tick();

        // 3: drain in order
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (16) begin
            @(negedge clk);
            tick();
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("drain_count", 32'(count), 32'h0);
        check("drain_out_valid", 32'(bus.out_valid), 32'h0);
        tick();

        // 4: random traffic, 1000 words
        n_push = 0;
        cyc = 0;
        while ((n_push < 1000 || q.size() != 0) && cyc < 20000) begin
            bus.in_valid  = (n_push < 1000) && ($urandom_range(1, 0) == 1);
            bus.in_data   = 8'($urandom_range(255, 0));
            bus.out_ready = ($urandom_range(1, 0) == 1);
            @(negedge clk);
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("rand_done", 32'(n_push >= 1000 && q.size() == 0), 32'h1);
        @(negedge clk);
        check("rand_err", 32'(err), 32'h0);
        check("rand_count", 32'(count), 32'h0);
        tick();

        // 5: clear with data queued and pointers off zero
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = 8'h20 + 8'(i);
            @(negedge clk);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            tick();
        end
        bus.out_ready = 1'b0;
        chk_cnt = 1'b0;
        q.delete();
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        @(negedge clk);
        check("clr_in_ready", 32'(bus.in_ready), 32'h0);
        check("clr_wr_strobe", 32'(bank_wr_valid), 32'h0);
        check("clr_out_valid", 32'(bus.out_valid), 32'h0);
        tick();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_count", 32'(count), 32'h0);
        check("flush_bank_clear", 32'(bank_clear), 32'hF);
        tick();
        chk_cnt = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h30;
        @(negedge clk);
        check("post_clr_wr_bank", 32'(bank_wr_valid), 32'h1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_clr_rd_bank", 32'(bank_rd_ready), 32'h1);
        tick();
        bus.out_ready = 1'b0;

        // 6: full with simultaneous push and pop
        bus.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_data = 8'h40 + 8'(i);
            @(negedge clk);
            tick();
        end
        bus.in_data   = 8'h77;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("both_in_ready", 32'(bus.in_ready), 32'h0);
        check("both_out_valid", 32'(bus.out_valid), 32'h1);
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("after_pop_count", 32'(count), 32'd15);
        check("after_pop_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("final_drained", 32'(q.size()), 32'h0);
        @(negedge clk);
        check("final_count", 32'(count), 32'h0);
        check("final_err", 32'(err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
